// File: rtl/jtag_host.sv
// JTAG host: converts DMI scan requests into IR/DR scans and returns the captured DR, 45 TCK periods per scan (+11 when the IR must be loaded).
// Backpressure: req_ready stays low while a scan or an unconsumed response is pending; the response is held until rsp_ready.
module jtag_host #(
    parameter int                CLK_DIV   = 4,
    parameter int                IR_LEN    = 5,
    parameter logic [IR_LEN-1:0] DMI_IR    = 5'h11,
    parameter int                DMI_ABITS = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [DMI_ABITS-1:0] req_addr,
    input  logic [31:0]          req_data,
    input  logic [1:0]           req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DMI_ABITS-1:0] rsp_addr,
    output logic [31:0]          rsp_data,
    output logic [1:0]           rsp_op,
    output logic                 jtag_pin_TCK,
    output logic                 jtag_pin_TMS,
    output logic                 jtag_pin_TDI,
    input  logic                 jtag_pin_TDO
);
    localparam int DR_LEN    = DMI_ABITS + 34;
    localparam int IR_TICKS  = IR_LEN + 6;
    localparam int DR_TICKS  = DR_LEN + 5;
    localparam int MAX_TICKS = (IR_TICKS > DR_TICKS) ? IR_TICKS : DR_TICKS;
    localparam int IDXW      = $clog2(MAX_TICKS);
    localparam int DIVW      = $clog2(2 * CLK_DIV);

    typedef enum logic [2:0] {ST_TRST, ST_IDLE, ST_IR, ST_DR, ST_RSP} state_t;

    state_t            state, nxt_state;
    logic [DIVW-1:0]   div_cnt;
    logic [IDXW-1:0]   idx, nxt_idx;
    logic [DR_LEN-1:0] sr;
    logic              ir_loaded;
    logic              tick_rise, tick_end, last_tick, shift_tick;
    logic              pat_tms, pat_tdi;
    logic [IR_LEN-1:0] ir_bits;
    int                ni;

    assign tick_rise  = div_cnt == DIVW'(CLK_DIV - 1);
    assign tick_end   = div_cnt == DIVW'(2 * CLK_DIV - 1);
    assign shift_tick = (state == ST_DR) && (int'(idx) >= 3) && (int'(idx) < DR_LEN + 3);

    always_comb begin
        case (state)
            ST_TRST: last_tick = idx == IDXW'(5);
            ST_IR:   last_tick = idx == IDXW'(IR_TICKS - 1);
            ST_DR:   last_tick = idx == IDXW'(DR_TICKS - 1);
            default: last_tick = 1'b0;
        endcase
    end

    // Which tick comes next; only consumed at a tick boundary or on request accept.
    always_comb begin
        nxt_state = state;
        nxt_idx   = idx + IDXW'(1);
        if (state == ST_IDLE) begin
            nxt_state = ir_loaded ? ST_DR : ST_IR;
            nxt_idx   = '0;
        end else if (last_tick) begin
            nxt_idx = '0;
            case (state)
                ST_TRST: nxt_state = ST_IDLE;
                ST_IR:   nxt_state = ST_DR;
                default: nxt_state = ST_RSP;
            endcase
        end
    end

    // TMS/TDI for the upcoming tick. In DR shift, sr[0] is already the next bit
    // because sr shifted on the rising edge of the tick just finishing.
    always_comb begin
        ni      = int'(nxt_idx);
        pat_tms = 1'b0;
        pat_tdi = 1'b0;
        ir_bits = '0;
        case (nxt_state)
            ST_TRST: pat_tms = ni < 5;
            ST_IR: begin
                if (ni < 2) begin
                    pat_tms = 1'b1;
                end else if (ni >= 4 && ni < IR_LEN + 4) begin
                    ir_bits = DMI_IR >> (ni - 4);
                    pat_tdi = ir_bits[0];
                    pat_tms = ni == IR_LEN + 3;
                end else if (ni == IR_LEN + 4) begin
                    pat_tms = 1'b1;
                end
            end
            ST_DR: begin
                if (ni == 0) begin
                    pat_tms = 1'b1;
                end else if (ni >= 3 && ni < DR_LEN + 3) begin
                    pat_tdi = sr[0];
                    pat_tms = ni == DR_LEN + 2;
                end else if (ni == DR_LEN + 3) begin
                    pat_tms = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_TRST;
            div_cnt      <= '0;
            idx          <= '0;
            sr           <= '0;
            ir_loaded    <= 1'b0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_addr     <= '0;
            rsp_data     <= '0;
            rsp_op       <= '0;
            jtag_pin_TCK <= 1'b0;
            jtag_pin_TMS <= 1'b1;
            jtag_pin_TDI <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        sr           <= {req_addr, req_data, req_op};
                        req_ready    <= 1'b0;
                        state        <= nxt_state;
                        idx          <= nxt_idx;
                        div_cnt      <= '0;
                        jtag_pin_TMS <= pat_tms;
                        jtag_pin_TDI <= pat_tdi;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    if (tick_end) begin
                        div_cnt      <= '0;
                        jtag_pin_TCK <= 1'b0;
                        jtag_pin_TMS <= pat_tms;
                        jtag_pin_TDI <= pat_tdi;
                        state        <= nxt_state;
                        idx          <= nxt_idx;
                        if (last_tick) begin
                            case (state)
                                ST_TRST: req_ready <= 1'b1;
                                ST_IR:   ir_loaded <= 1'b1;
                                default: begin
                                    rsp_valid <= 1'b1;
                                    rsp_addr  <= sr[DR_LEN-1 -: DMI_ABITS];
                                    rsp_data  <= sr[33:2];
                                    rsp_op    <= sr[1:0];
                                end
                            endcase
                        end
                    end else begin
                        div_cnt <= div_cnt + DIVW'(1);
                        if (tick_rise) begin
                            jtag_pin_TCK <= 1'b1;
                            if (shift_tick)
                                sr <= {jtag_pin_TDO, sr[DR_LEN-1:1]};
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_host.sv
// Bench for jtag_host: a behavioural TAP/DTM target on the pins and a response scoreboard.
module tb_jtag_host;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_op = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [5:0]  rsp_addr;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_op;
    logic        jtag_pin_TCK, jtag_pin_TMS, jtag_pin_TDI;
    logic        tdo = 1'b0;

    always #5 clk = ~clk;

    jtag_host dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_op(rsp_op),
        .jtag_pin_TCK(jtag_pin_TCK), .jtag_pin_TMS(jtag_pin_TMS),
        .jtag_pin_TDI(jtag_pin_TDI), .jtag_pin_TDO(tdo)
    );

    typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                      SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_t;

    tap_t        tap = TLR;
    logic [39:0] dr_sh = '0;
    logic [39:0] cap = '0;
    logic [39:0] last_dr = '0;
    logic [39:0] forced_val = {6'h29, 32'h56969696, 2'b11};
    logic [4:0]  ir_sh = '0;
    logic [4:0]  ir = 5'h01;
    logic [31:0] regs [0:63];
    logic [63:0] written = '0;
    logic [5:0]  ma;
    logic        tms_log[$];
    logic        ir_tdi_log[$];
    logic [39:0] sb[$];
    int          dr_cnt = 0, ir_updates = 0, tck_rises = 0, cap_num = 0, rsp_cnt = 0;
    int          force_cap_num = -1;
    int          t0 = 0;
    int          n_tests = 0, n_fail = 0;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TLR:     return m ? TLR   : RTI;
            RTI:     return m ? SELDR : RTI;
            SELDR:   return m ? SELIR : CAPDR;
            CAPDR:   return m ? EX1DR : SHDR;
            SHDR:    return m ? EX1DR : SHDR;
            EX1DR:   return m ? UPDR  : PADR;
            PADR:    return m ? EX2DR : PADR;
            EX2DR:   return m ? UPDR  : SHDR;
            UPDR:    return m ? SELDR : RTI;
            SELIR:   return m ? TLR   : CAPIR;
            CAPIR:   return m ? EX1IR : SHIR;
            SHIR:    return m ? EX1IR : SHIR;
            EX1IR:   return m ? UPIR  : PAIR;
            PAIR:    return m ? EX2IR : PAIR;
            EX2IR:   return m ? UPIR  : SHIR;
            default: return m ? SELDR : RTI;
        endcase
    endfunction

    // DTM target: dmi register 0x11 resets to 0xC82; a read returns on the next capture.
    always @(posedge jtag_pin_TCK) begin
        tck_rises++;
        tms_log.push_back(jtag_pin_TMS);
        case (tap)
            CAPDR: begin
                cap_num++;
                dr_sh  = (cap_num == force_cap_num) ? forced_val : cap;
                dr_cnt = 0;
            end
            SHDR: begin
                dr_sh = {jtag_pin_TDI, dr_sh[39:1]};
                dr_cnt++;
            end
            CAPIR: ir_sh = 5'b00001;
            SHIR: begin
                ir_sh = {jtag_pin_TDI, ir_sh[4:1]};
                ir_tdi_log.push_back(jtag_pin_TDI);
            end
            UPIR: begin
                ir = ir_sh;
                ir_updates++;
            end
            UPDR: begin
                if (ir == 5'h11 && dr_cnt == 40) begin
                    last_dr = dr_sh;
                    ma = dr_sh[39:34];
                    case (dr_sh[1:0])
                        2'd1: cap = {ma, written[ma] ? regs[ma] : ((ma == 6'h11) ? 32'hC82 : 32'h0), 2'b00};
                        2'd2: begin
                            regs[ma] = dr_sh[33:2];
                            written[ma] = 1'b1;
                            cap = {ma, 32'h0, 2'b00};
                        end
                        default: cap = {ma, 32'h0, 2'b00};
                    endcase
                end
            end
            default: ;
        endcase
        tap = tap_next(tap, jtag_pin_TMS);
        if (tap == TLR) ir = 5'h01;
    end

    always @(negedge jtag_pin_TCK)
        tdo = (tap == SHDR) ? dr_sh[0] : ((tap == SHIR) ? ir_sh[0] : 1'b0);

    always @(posedge rsp_valid) rsp_cnt++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [5:0] a, input logic [31:0] d, input logic [1:0] op);
        req_addr  = a;
        req_data  = d;
        req_op    = op;
        req_valid = 1'b1;
        for (int k = 0; k < 500; k++) begin
            if (req_ready) break;
            @(negedge clk);
        end
        check("req_ready_at_send", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        t0 = tck_rises;
    endtask

    task automatic receive(input string tag, input int exp_ticks, input int hold);
        logic [39:0] e;
        logic        bad;
        for (int k = 0; k < 4000; k++) begin
            if (rsp_valid) break;
            @(negedge clk);
        end
        check({tag, "_valid"}, rsp_valid, 1);
        check({tag, "_ticks"}, tck_rises - t0, exp_ticks);
        check({tag, "_sb_nonempty"}, sb.size() > 0, 1);
        e = (sb.size() > 0) ? sb.pop_front() : 40'hx;
        bad = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || {rsp_addr, rsp_data, rsp_op} !== e)
                bad = 1'b1;
        end
        if (hold > 0) check({tag, "_hold_stable"}, bad, 0);
        check({tag, "_addr"}, rsp_addr, e[39:34]);
        check({tag, "_data"}, rsp_data, e[33:2]);
        check({tag, "_op"}, rsp_op, e[1:0]);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_valid_dropped"}, rsp_valid, 0);
        check({tag, "_req_ready_back"}, req_ready, 1);
    endtask

    initial begin
        int          base;
        logic [5:0]  tms_bits;
        logic [4:0]  irb;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tck", jtag_pin_TCK, 0);
        check("rst_tms", jtag_pin_TMS, 1);
        check("rst_tdi", jtag_pin_TDI, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_fields", {rsp_addr, rsp_data, rsp_op}, 40'h0);

        // TAP reset sequence after release
        base = tms_log.size();
        rst  = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (req_ready) break;
            @(negedge clk);
        end
        check("trst_req_ready", req_ready, 1);
        check("trst_rise_count", tms_log.size() - base, 6);
        tms_bits = 'x;
        for (int i = 0; i < 6; i++)
            if (base + i < tms_log.size()) tms_bits[i] = tms_log[base + i];
        check("trst_tms_seq", tms_bits, 6'b011111);
        check("trst_tck_parked", jtag_pin_TCK, 0);

        // First request: IR scan then DR scan
        base = ir_tdi_log.size();
        sb.push_back(40'h0);
        send(6'h10, 32'h0000_0001, 2'd2);
        receive("first", 56, 0);
        check("ir_shift_count", ir_tdi_log.size() - base, 5);
        irb = 'x;
        for (int i = 0; i < 5; i++)
            if (base + i < ir_tdi_log.size()) irb[i] = ir_tdi_log[base + i];
        check("ir_tdi_bits", irb, 5'h11);
        check("dr_tdi_stream", last_dr, {6'h10, 32'h0000_0001, 2'b10});

        // IR already loaded; target reports busy
        force_cap_num = cap_num + 1;
        sb.push_back({6'h29, 32'h5696_9696, 2'b11});
        send(6'h12, 32'hDEAD_BEEF, 2'd2);
        receive("busy", 45, 0);
        check("ir_loaded_once", ir_updates, 1);

        // Read then nop; the nop response carries the read data, held for 20 clk
        sb.push_back({6'h12, 32'h0, 2'b00});
        send(6'h11, 32'h0, 2'd1);
        receive("read", 45, 0);
        sb.push_back({6'h11, 32'h0000_0C82, 2'b00});
        send(6'h00, 32'h0, 2'd0);
        receive("nop_rdata", 45, 20);

        // Reset in the middle of a DR scan
        base = rsp_cnt;
        send(6'h05, 32'h1234_5678, 2'd2);
        for (int k = 0; k < 4000; k++) begin
            if (tap == SHDR && dr_cnt == 20) break;
            @(negedge clk);
        end
        check("abort_at_bit20", dr_cnt, 20);
        rst = 1'b1;
        #1;
        check("abort_tck", jtag_pin_TCK, 0);
        check("abort_tms", jtag_pin_TMS, 1);
        check("abort_req_ready", req_ready, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_rsp_cleared", {rsp_addr, rsp_data, rsp_op}, 40'h0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (req_ready) break;
            @(negedge clk);
        end
        check("abort_no_rsp", rsp_cnt - base, 0);

        // IR must be reshifted after the reset
        sb.push_back({6'h00, 32'h0, 2'b00});
        send(6'h10, 32'h0, 2'd1);
        receive("reir_read", 56, 0);
        check("ir_reloaded", ir_updates, 2);
        sb.push_back({6'h10, 32'h0000_0001, 2'b00});
        send(6'h00, 32'h0, 2'd0);
        receive("reir_nop", 45, 0);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
